// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Contents:
//   state_e       - sequencer state encodings (also exported on the debug port)
//   OP_* / FN_*   - opcode and funct field values the controller recognises
//   *_SEL / ALUOP - mux-select and ALU operation constants
//   decode_next   - DECODE-state dispatch; StFetch means "unsupported opcode"
package mips_mc_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAddr = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StJreg    = 4'd11,
    StError   = 4'd15
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes (IR[5:0]) for R-type
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // Memory address select
  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  // Register-file destination
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Writeback source
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  // ALU operand A
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALU operand B
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [3:0] ALUOP_ADD = 4'b0000;

  // Where DECODE goes for a given instruction; StFetch flags an unsupported opcode.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    case (op)
      OP_RTYPE:                nxt = (fn == FN_JR || fn == FN_JALR) ? StJreg : StExec;
      OP_LW, OP_SW:            nxt = StMemAddr;
      OP_BEQ:                  nxt = StBranch;
      OP_J, OP_JAL:            nxt = StJump;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_LUI: nxt = StExec;
      default:                 nxt = StFetch;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_op_dec.sv
// OpCode -> ALUOp mapping, shared with the single-cycle datapath.
// Ports:
//   opcode - IR[31:26]
//   alu_op - [2:0] operation class, [3] = opcode[0] (unsigned/variant select)
module mc_alu_op_dec
  import mips_mc_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = 4'b0000;
    case (opcode)
      OP_RTYPE:          alu_op[2:0] = 3'b010;
      OP_BEQ:            alu_op[2:0] = 3'b001;
      OP_ANDI:           alu_op[2:0] = 3'b100;
      OP_SLTI, OP_SLTIU: alu_op[2:0] = 3'b101;
      default:           alu_op[2:0] = 3'b000;
    endcase
    alu_op[3] = opcode[0];
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer for a shared instruction/data memory port.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and issues
// per-cycle datapath enables and mux selects.
// Ports:
//   clk, reset_n         - clock (rising edge), async active-low reset
//   OpCode, Funct, zero  - instruction fields and ALU zero flag
//   mem_ready, stall     - memory completion handshake, freeze request
//   PCWrite..ALUOp       - datapath controls
//   state                - current state (debug)
//   instr_done, illegal  - per-instruction pulses
//   mem_err              - sticky memory timeout flag
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [3:0]       dec_alu_op;
  logic             is_rtype, is_shift, mem_wait, timeout_hit;

  mc_alu_op_dec u_alu_op_dec (
    .opcode (OpCode),
    .alu_op (dec_alu_op)
  );

  assign is_rtype = (OpCode == OP_RTYPE);
  assign is_shift = is_rtype && (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA);

  // A memory state waiting on the port this cycle
  assign mem_wait    = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
  assign timeout_hit = mem_wait && (cnt_q == TimeoutCnt);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StError;
      end
      StDecode:  state_d = decode_next(OpCode, Funct);
      StMemAddr: state_d = (OpCode == OP_SW) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)        state_d = StMemWb;
        else if (timeout_hit) state_d = StError;
      end
      StMemWr: begin
        if (mem_ready)        state_d = StFetch;
        else if (timeout_hit) state_d = StError;
      end
      StExec:   state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump, StJreg: state_d = StFetch;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
    if (stall) state_d = state_q;
  end

  // Wait counter and sticky error
  always_comb begin
    cnt_d = cnt_q;
    if (stall)                  cnt_d = cnt_q;
    else if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)          cnt_d = cnt_q + 1'b1;
    mem_err_d = mem_err_q | (state_d == StError);
  end

  // Outputs
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = IORD_PC;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = REGDST_RT;
    MemtoReg   = MEMTOREG_ALU;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    ExtOp      = 1'b0;
    LuOp       = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUOp      = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IorD    = IORD_PC;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = PCSRC_ALU;
        end
      end
      StDecode: begin
        // Precompute the branch target while the opcode is decoded
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_IMM_SH2;
        if (decode_next(OpCode, Funct) == StFetch) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      StMemAddr: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = IORD_ALUOUT;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = IORD_ALUOUT;
        if (mem_ready) instr_done = 1'b1;
      end
      StMemWb: begin
        RegWrite   = 1'b1;
        RegDst     = REGDST_RT;
        MemtoReg   = MEMTOREG_MDR;
        instr_done = 1'b1;
      end
      StExec: begin
        ALUSrcA = is_shift ? SRCA_SHAMT : SRCA_REGA;
        ALUSrcB = is_rtype ? SRCB_REGB : SRCB_IMM;
        ALUOp   = dec_alu_op;
      end
      StAluWb: begin
        RegWrite   = 1'b1;
        RegDst     = is_rtype ? REGDST_RD : REGDST_RT;
        MemtoReg   = MEMTOREG_ALU;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = dec_alu_op;
        PCSrc      = PCSRC_ALUOUT;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      StJump: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_JUMP;
        instr_done = 1'b1;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = MEMTOREG_PC;
        end
      end
      StJreg: begin
        PCWrite    = 1'b1;
        PCSrc      = PCSRC_REGA;
        instr_done = 1'b1;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
          MemtoReg = MEMTOREG_PC;
        end
      end
      default: ;
    endcase

    if (state_q != StIdle && state_q != StError) begin
      ExtOp = (OpCode != OP_ANDI);
      LuOp  = (OpCode == OP_LUI);
    end

    // Freeze: suppress every architectural write; illegal is also held off so it
    // still pulses once, in the cycle DECODE actually retires.
    if (stall) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] OpCode, Funct;
  logic       zero, mem_ready, stall;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc;
  logic       ExtOp, LuOp;
  logic [3:0] ALUOp, state;
  logic       instr_done, illegal, mem_err;
  logic [24:0] outs;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ExtOp      (ExtOp),
    .LuOp       (LuOp),
    .PCSrc      (PCSrc),
    .ALUOp      (ALUOp),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal),
    .mem_err    (mem_err)
  );

  // mem_err is the LSB so "only mem_err set" reads as 1
  assign outs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, ExtOp, LuOp, PCSrc, ALUOp, instr_done, illegal, mem_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset_n = 1'b0; OpCode = 6'h00; Funct = 6'h00; zero = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    reset_n = 1'b1; OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
    #1;
    chk("idle_outs", 32'(outs), 32'd0);

    // add
    tick(); cyc = 1;
    chk("add_fetch_state", 32'(state), 32'd1);
    chk("add_fetch", 32'({IRWrite, PCWrite, MemRead, IorD, ALUSrcA, ALUSrcB, PCSrc}),
        32'({1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00}));
    tick();
    chk("add_decode_state", 32'(state), 32'd2);
    chk("add_decode", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({2'b00, 2'b11, 4'b0000}));
    tick();
    chk("add_exec_state", 32'(state), 32'd7);
    chk("add_exec", 32'({ALUSrcA, ALUSrcB, ALUOp, RegWrite, instr_done}),
        32'({2'b01, 2'b00, 4'b0010, 1'b0, 1'b0}));
    tick();
    chk("add_wb_state", 32'(state), 32'd8);
    chk("add_wb", 32'({RegWrite, RegDst, MemtoReg, instr_done}), 32'({1'b1, 2'b01, 2'b00, 1'b1}));
    chk("add_len", 32'(cyc), 32'd4);
    tick();
    chk("add_back_fetch", 32'(state), 32'd1);

    // asynchronous reset in the middle of EXEC
    tick(); tick();
    chk("mid_exec_state", 32'(state), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_outs", 32'(outs), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_to_fetch", 32'(state), 32'd1);
    tick();
    chk("rst_to_decode", 32'(state), 32'd2);
    tick(); tick(); tick();
    chk("add2_back_fetch", 32'(state), 32'd1);

    // lw with 3 wait cycles in MEM_RD
    OpCode = 6'h23; cyc = 1;
    tick(); tick();
    chk("lw_addr_state", 32'(state), 32'd3);
    chk("lw_addr", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({2'b01, 2'b10, 4'b0000}));
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_rd_state", 32'(state), 32'd4);
    chk("lw_rd", 32'({MemRead, IorD, RegWrite, instr_done}), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
    tick(); tick(); tick();
    chk("lw_rd_wait", 32'(state), 32'd4);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb", 32'({RegWrite, RegDst, MemtoReg, instr_done}), 32'({1'b1, 2'b00, 2'b01, 1'b1}));
    chk("lw_len", 32'(cyc), 32'd8);
    tick();

    // beq taken
    OpCode = 6'h04; zero = 1'b1; cyc = 1;
    tick(); tick();
    chk("beq_t_state", 32'(state), 32'd9);
    chk("beq_t", 32'({PCWrite, PCSrc, ALUOp, ALUSrcA, ALUSrcB, instr_done}),
        32'({1'b1, 2'b01, 4'b0001, 2'b01, 2'b00, 1'b1}));
    chk("beq_t_len", 32'(cyc), 32'd3);
    tick();

    // beq not taken
    zero = 1'b0; cyc = 1;
    tick(); tick();
    chk("beq_nt", 32'({PCWrite, PCSrc, ALUOp, instr_done}), 32'({1'b0, 2'b01, 4'b0001, 1'b1}));
    chk("beq_nt_len", 32'(cyc), 32'd3);
    tick();

    // jal
    OpCode = 6'h03;
    tick(); tick();
    chk("jal_state", 32'(state), 32'd10);
    chk("jal", 32'({PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, instr_done}),
        32'({1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1}));
    tick();

    // jalr
    OpCode = 6'h00; Funct = 6'h09;
    tick(); tick();
    chk("jalr_state", 32'(state), 32'd11);
    chk("jalr", 32'({PCWrite, PCSrc, RegWrite, RegDst, MemtoReg, instr_done}),
        32'({1'b1, 2'b11, 1'b1, 2'b01, 2'b10, 1'b1}));
    tick();

    // sw
    OpCode = 6'h2b; cyc = 1;
    tick(); tick(); tick();
    chk("sw_state", 32'(state), 32'd6);
    chk("sw", 32'({MemWrite, IorD, MemRead, RegWrite, instr_done}),
        32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));
    chk("sw_len", 32'(cyc), 32'd4);
    tick();

    // andi: zero-extend
    OpCode = 6'h0c;
    tick(); tick();
    chk("andi_exec", 32'({ExtOp, LuOp, ALUSrcA, ALUSrcB, ALUOp}),
        32'({1'b0, 1'b0, 2'b01, 2'b10, 4'b0100}));
    tick();
    chk("andi_wb", 32'({RegWrite, RegDst, instr_done}), 32'({1'b1, 2'b00, 1'b1}));
    tick();

    // lui
    OpCode = 6'h0f;
    tick(); tick();
    chk("lui_exec", 32'({ExtOp, LuOp, ALUOp}), 32'({1'b1, 1'b1, 4'b1000}));
    tick(); tick();

    // sll uses shamt
    OpCode = 6'h00; Funct = 6'h00;
    tick(); tick();
    chk("sll_exec", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({2'b10, 2'b00, 4'b0010}));
    tick(); tick();

    // sltiu
    OpCode = 6'h0b;
    tick(); tick();
    chk("sltiu_exec", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'({2'b01, 2'b10, 4'b1101}));
    tick(); tick();

    // illegal opcode
    OpCode = 6'h3f;
    tick();
    chk("ill_decode", 32'({state, illegal, instr_done}), 32'({4'd2, 1'b1, 1'b1}));
    tick();
    chk("ill_back", 32'({state, illegal}), 32'({4'd1, 1'b0}));

    // stall in FETCH with mem_ready high
    stall = 1'b1; OpCode = 6'h02;
    #1;
    chk("stall_fetch", 32'({IRWrite, PCWrite, MemRead, instr_done}), 32'({1'b0, 1'b0, 1'b1, 1'b0}));
    tick();
    chk("stall_hold1", 32'(state), 32'd1);
    tick();
    chk("stall_hold2", 32'(state), 32'd1);
    stall = 1'b0;
    #1;
    chk("unstall_fetch", 32'({IRWrite, PCWrite}), 32'({1'b1, 1'b1}));
    tick();
    chk("unstall_decode", 32'(state), 32'd2);
    tick();
    chk("j", 32'({state, PCWrite, PCSrc, RegWrite, instr_done}),
        32'({4'd10, 1'b1, 2'b10, 1'b0, 1'b1}));
    tick();

    // mem_ready arriving on the TIMEOUT count still completes the fetch
    mem_ready = 1'b0;
    repeat (16) tick();
    chk("tmo_edge_wait", 32'(state), 32'd1);
    mem_ready = 1'b1;
    tick();
    chk("tmo_edge_ok", 32'({state, mem_err}), 32'({4'd2, 1'b0}));
    tick(); tick();

    // timeout into ERROR
    mem_ready = 1'b0;
    repeat (16) tick();
    chk("tmo_wait16", 32'(state), 32'd1);
    tick();
    chk("tmo_err_state", 32'(state), 32'd15);
    chk("tmo_err_outs", 32'(outs), 32'd1);
    mem_ready = 1'b1;
    tick(); tick();
    chk("err_sticky", 32'({state, mem_err}), 32'({4'd15, 1'b1}));
    reset_n = 1'b0;
    #1;
    chk("err_cleared", 32'({state, mem_err}), 32'({4'd0, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
